// File: rtl/program_loader.sv
// Serial program loader: receives a count byte, N big-endian 16-bit words and an XOR checksum,
// writes the words into instruction memory and holds the CPU in reset until a good load completes.
module program_loader #(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic                timed_out;
    logic [7:0]          checksum;
    logic [ADDR_W:0]     word_target;
    logic [ADDR_W:0]     words_nxt;
    logic [IDLE_W-1:0]   idle_cnt;

    assign accept    = rx_valid && rx_ready;
    assign timed_out = !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign words_nxt = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = COUNT;
            end
            COUNT: begin
                rx_ready = 1'b1;
                if (accept)         state_nxt = (rx_data > MAX_N) ? ERR : HI;
                else if (timed_out) state_nxt = ERR;
            end
            HI: begin
                rx_ready = 1'b1;
                if (accept)         state_nxt = LO;
                else if (timed_out) state_nxt = ERR;
            end
            LO: begin
                rx_ready = 1'b1;
                if (accept)         state_nxt = WRITE;
                else if (timed_out) state_nxt = ERR;
            end
            WRITE: begin
                imem_we   = 1'b1;
                state_nxt = (words_nxt == word_target) ? CSUM : HI;
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (accept)         state_nxt = (rx_data == checksum) ? DONE : ERR;
                else if (timed_out) state_nxt = ERR;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = COUNT;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = COUNT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            word_target  <= '0;
            checksum     <= '0;
            idle_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        imem_addr    <= '0;
                        words_loaded <= '0;
                        checksum     <= '0;
                        idle_cnt     <= '0;
                    end
                end
                COUNT, HI, LO, CSUM: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        checksum <= checksum ^ rx_data;
                        if (state == COUNT)
                            word_target <= (rx_data == 8'd0) ? (ADDR_W+1)'(MAX_WORDS)
                                                             : rx_data[ADDR_W:0];
                        if (state == HI) imem_wdata[15:8] <= rx_data;
                        if (state == LO) imem_wdata[7:0]  <= rx_data;
                    end else begin
                        idle_cnt <= idle_cnt + {{(IDLE_W-1){1'b0}}, 1'b1};
                    end
                end
                WRITE: begin
                    // Address is 6 bits wide so the 64th word wraps it back to 0.
                    imem_addr    <= imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    words_loaded <= words_nxt;
                    idle_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the maximum idle cycles allowed between accepted bytes during a load.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the instruction memory address width, matching the 6-bit PC.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load.
REQ-006 SHALL have port rx_valid, input, 1 bit: a byte is present on rx_data.
REQ-007 SHALL have port rx_data, input, 8 bits: the serial-link byte.
REQ-008 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we, output, 1 bit: instruction memory write strobe.
REQ-010 SHALL have port imem_addr, output, ADDR_W bits: instruction memory write address.
REQ-011 SHALL have port imem_wdata, output, 16 bits: instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1 bit: holds the CPU program counter and control state in reset.
REQ-013 SHALL have port done, output, 1 bit: the last load completed with a good checksum.
REQ-014 SHALL have port error, output, 1 bit: the last load failed.
REQ-015 SHALL have port words_loaded, output, ADDR_W+1 bits: the count of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, COUNT, HI, LO, WRITE, CSUM, DONE and ERR.
REQ-017 SHALL treat a byte as accepted only at a rising edge where rx_valid=1 and rx_ready=1.
REQ-018 SHALL drive rx_ready=1 in COUNT, HI, LO and CSUM, and 0 in all other states.
REQ-019 SHALL, on start=1 in IDLE, DONE or ERR, enter COUNT with imem_addr=0, words_loaded=0, checksum=0, done=0, error=0 and cpu_hold=1.
REQ-020 SHALL ignore start in COUNT, HI, LO, WRITE and CSUM.
REQ-021 SHALL take the accepted count byte N as follows: N=0 means 64 words; N in 1..64 means N words and the next state is HI; N>64 means the next state is ERR.
REQ-022 SHALL, in HI, latch the accepted byte as data[15:8] and then go to LO.
REQ-023 SHALL, in LO, latch the accepted byte as data[7:0] and then go to WRITE.
REQ-024 SHALL, in WRITE, assert imem_we for exactly one cycle with the current imem_addr and imem_wdata.
REQ-025 SHALL, on the cycle after the WRITE pulse, increment imem_addr and words_loaded.
REQ-026 SHALL, after a write, go to CSUM if words_loaded equals N, otherwise to HI.
REQ-027 SHALL, after the 64th word, let imem_addr wrap from 63 to 0 with no further write issued.
REQ-028 SHALL XOR the count byte and every data byte into an 8-bit running checksum.
REQ-029 SHALL, in CSUM, go to DONE if the accepted byte equals the running checksum, otherwise to ERR.
REQ-030 SHALL, in DONE, hold done=1 and cpu_hold=0; in ERR, hold error=1 and cpu_hold=1.
REQ-031 SHALL keep done and error mutually exclusive at all times.
REQ-032 SHALL, in COUNT, HI, LO and CSUM, count the cycles without an accepted byte, clearing the count on state entry and on each accepted byte.
REQ-033 SHALL enter ERR when the idle count reaches TIMEOUT.
REQ-034 SHALL hold imem_we=0 in every state except WRITE.
REQ-035 SHALL keep imem_wdata stable from LO acceptance through the end of WRITE.

Reset
REQ-036 SHALL, while reset=0, immediately force: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, done=0, error=0, cpu_hold=1, checksum=0, idle count=0.
REQ-037 SHALL abort a load in progress on reset assertion with no partial write strobe, and SHALL remain in IDLE after release until start.

Verification
REQ-038 SHALL cover: reset asserted mid-HI -> imem_we=0 and cpu_hold=1 at once; IDLE after release.
REQ-039 SHALL cover: start; bytes 02,12,34,AB,CD,42 -> writes addr0=0x1234 and addr1=0xABCD; done=1, cpu_hold=0, words_loaded=2.
REQ-040 SHALL cover: the same stream with checksum byte 43 -> error=1, done=0, cpu_hold=1.
REQ-041 SHALL cover: count 00 and 128 data bytes plus correct checksum -> 64 writes at addr 0..63; words_loaded=64; imem_addr=0 at DONE.
REQ-042 SHALL cover: count byte 41 -> ERR the next cycle with no imem_we pulse.
REQ-043 SHALL cover: rx_valid held low TIMEOUT cycles in LO -> error=1, and start is ignored until ERR is reached.
